// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and constants for the elastic pipeline stage.
//            Holds the occupancy state enum, the default widths and the
//            saturating-counter maximum helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // The encoding equals the number of held entries, so occupancy can be
  // read straight out of the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // All-ones value for a counter of the given width (widths up to 32).
  function automatic logic [31:0] sat_max(input int unsigned width);
    logic [31:0] v;
    if (width >= 32) begin
      v = 32'hFFFF_FFFF;
    end else begin
      v = (32'd1 << width) - 32'd1;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module   : pipe_slot
// Purpose  : One pipeline entry (payload + control field) with load enable
//            and a control-field clear.
// Ports    : clk, rst_n (async, active low)
//            i_load  - capture i_data/i_ctrl
//            i_clr   - zero the control field (wins over i_load); the
//                      payload keeps its stale value
//            i_data/i_ctrl -> o_data/o_ctrl (registered)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_ctrl <= '0;
    end else if (i_clr) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_data <= i_data;
      r_ctrl <= i_ctrl;
    end
  end

  assign o_data = r_data;
  assign o_ctrl = r_ctrl;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_hs.sv
// ============================================================================
// Module   : pipe_stage_hs
// Purpose  : Elastic valid/ready pipeline stage carrying a payload and a
//            control field, with flush, optional 2-entry skid buffer and a
//            saturating stall-cycle counter.
// Config   : PIPE_SKID_EN - when defined, adds the skid slot (TWO state),
//            registered o_in_ready, occupancy up to 2. When undefined, a
//            single slot with o_in_ready = !o_out_valid || i_out_ready.
// Ports    : clk, rst_n (async, active low), i_flush
//            i_in_valid/o_in_ready/i_in_data/i_in_ctrl   - upstream side
//            o_out_valid/i_out_ready/o_out_data/o_out_ctrl - downstream side
//            o_occupancy - entries held
//            i_clr_cnt/o_stall_cnt - stall counter clear / value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [1:0]        o_occupancy,
  input  logic              i_clr_cnt,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(sat_max(CNT_W));

  pipe_state_t       r_state;
  pipe_state_t       w_state_nxt;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_main_load;
  logic [DATA_W-1:0] w_main_src_data;
  logic [CTRL_W-1:0] w_main_src_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign o_out_valid = (r_state != ST_EMPTY);
  assign w_in_hs     = i_in_valid && o_in_ready;
  assign w_out_hs    = o_out_valid && i_out_ready;

`ifdef PIPE_SKID_EN
  logic              w_skid_load;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;

  // Ready depends only on the state register, breaking the ready chain.
  assign o_in_ready  = (r_state != ST_TWO);
  assign o_occupancy = r_state;

  // When draining from TWO the head is refilled from the skid slot.
  assign w_main_src_data = (r_state == ST_TWO) ? w_skid_data : i_in_data;
  assign w_main_src_ctrl = (r_state == ST_TWO) ? w_skid_ctrl : i_in_ctrl;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_skid_load),
    .i_clr  (i_flush),
    .i_data (i_in_data),
    .i_ctrl (i_in_ctrl),
    .o_data (w_skid_data),
    .o_ctrl (w_skid_ctrl)
  );
`else
  // Accept when empty or when the head leaves this same cycle.
  assign o_in_ready      = !o_out_valid || i_out_ready;
  assign o_occupancy     = {1'b0, r_state[0]};
  assign w_main_src_data = i_in_data;
  assign w_main_src_ctrl = i_in_ctrl;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_load = 1'b0;
`ifdef PIPE_SKID_EN
    w_skid_load = 1'b0;
`endif
    if (i_flush) begin
      // Handshakes in the flush cycle are discarded.
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_hs) begin
            w_state_nxt = ST_ONE;
            w_main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_hs && w_out_hs) begin
            w_main_load = 1'b1;
`ifdef PIPE_SKID_EN
          end else if (w_in_hs) begin
            w_state_nxt = ST_TWO;
            w_skid_load = 1'b1;
`endif
          end else if (w_out_hs) begin
            w_state_nxt = ST_EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        ST_TWO: begin
          if (w_out_hs) begin
            w_state_nxt = ST_ONE;
            w_main_load = 1'b1;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_main_load),
    .i_clr  (i_flush),
    .i_data (w_main_src_data),
    .i_ctrl (w_main_src_ctrl),
    .o_data (w_main_data),
    .o_ctrl (w_main_ctrl)
  );

  assign o_out_data = w_main_data;
  // A popped head keeps its ctrl bits in the slot; gating makes bubbles NOPs.
  assign o_out_ctrl = w_main_ctrl & {CTRL_W{o_out_valid}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_stall_cnt <= '0;
    end else if (o_out_valid && !i_out_ready && (r_stall_cnt != C_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
// ============================================================================
// Module   : tb_pipe_stage_hs
// Purpose  : Self-checking bench for pipe_stage_hs (both skid and non-skid
//            builds, selected by PIPE_SKID_EN). A queue-based reference model
//            predicts the stage contents and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_hs;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic        clr;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;

  logic        in_ready,  in_ready3;
  logic        out_valid, out_valid3;
  logic [31:0] out_data,  out_data3;
  logic [7:0]  out_ctrl,  out_ctrl3;
  logic [1:0]  occ,       occ3;
  logic [15:0] stall;
  logic [2:0]  stall3;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } ent_t;

  ent_t q[$];
  int   cnt;
  int   cnt3;

  always #5 clk = ~clk;

  pipe_stage_hs u_dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_ctrl(in_ctrl),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_ctrl(out_ctrl),
    .o_occupancy(occ), .i_clr_cnt(clr), .o_stall_cnt(stall)
  );

  pipe_stage_hs #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready3),
    .i_in_data(in_data), .i_in_ctrl(in_ctrl),
    .o_out_valid(out_valid3), .i_out_ready(out_ready),
    .o_out_data(out_data3), .o_out_ctrl(out_ctrl3),
    .o_occupancy(occ3), .i_clr_cnt(clr), .o_stall_cnt(stall3)
  );

  // Model's view of whether the stage can take an entry right now.
  function automatic bit exp_in_ready();
`ifdef PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit ov;
    bit ihs;
    bit ohs;
    ov  = q.size() > 0;
    ihs = in_valid && exp_in_ready();
    ohs = ov && out_ready;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (ohs) void'(q.pop_front());
      if (ihs) q.push_back({in_data, in_ctrl});
    end
    if (clr) begin
      cnt  = 0;
      cnt3 = 0;
    end else if (ov && !out_ready) begin
      if (cnt < 65535) cnt++;
      if (cnt3 < 7) cnt3++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 0; clr = 0;
    in_data = '0; in_ctrl = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    q.delete(); cnt = 0; cnt3 = 0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL rst_occ got %0d exp 0", occ); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    n_cmp++; if (stall !== 16'h0) begin n_bad++; $display("FAIL rst_stall got %0d exp 0", stall); end
    rst_n = 1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end

    // Mid-stream reset with the stage full.
    in_valid = 1; in_data = 32'h30; in_ctrl = 8'h11;
    tick();
    in_data = 32'h31; in_ctrl = 8'h12;
    tick();
    in_valid = 0;
    n_cmp++; if (occ !== 2'(CAP)) begin n_bad++; $display("FAIL mid_occ got %0d exp %0d", occ, CAP); end
    #2;
    rst_n = 0; #1;
    q.delete(); cnt = 0; cnt3 = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_ctrl !== 8'h0) begin n_bad++; $display("FAIL mid_rst_out_ctrl got %h exp 0", out_ctrl); end
    n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL mid_rst_occ got %0d exp 0", occ); end
    n_cmp++; if (stall !== 16'h0) begin n_bad++; $display("FAIL mid_rst_stall got %0d exp 0", stall); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst_out_data got %h exp 0", out_data); end
    @(posedge clk); #1;
    rst_n = 1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h10 + 32'(i); in_ctrl = 8'(i + 1);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
      n_cmp++; if (out_data !== 32'h10 + 32'(i)) begin n_bad++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, 32'h10 + 32'(i)); end
      n_cmp++; if (out_ctrl !== 8'(i + 1)) begin n_bad++; $display("FAIL stream_ctrl[%0d] got %h exp %h", i, out_ctrl, 8'(i + 1)); end
    end
    in_valid = 0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_end_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_ctrl !== 8'h0) begin n_bad++; $display("FAIL stream_end_ctrl got %h exp 0", out_ctrl); end
  endtask

`ifdef PIPE_SKID_EN
  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_data = 32'hA0; in_ctrl = 8'h03;
    tick();
    in_data = 32'hA1; in_ctrl = 8'h04;
    tick();
    n_cmp++; if (occ !== 2'd2) begin n_bad++; $display("FAIL bp_occ got %0d exp 2", occ); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (out_data !== 32'hA0) begin n_bad++; $display("FAIL bp_head got %h exp a0", out_data); end
    in_valid = 0; out_ready = 1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_reg got %b exp 0", in_ready); end
    tick();
    n_cmp++; if (out_data !== 32'hA1) begin n_bad++; $display("FAIL bp_second got %h exp a1", out_data); end
    n_cmp++; if (out_ctrl !== 8'h04) begin n_bad++; $display("FAIL bp_second_ctrl got %h exp 04", out_ctrl); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after got %b exp 1", in_ready); end
    n_cmp++; if (occ !== 2'd1) begin n_bad++; $display("FAIL bp_occ_after got %0d exp 1", occ); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained got %b exp 0", out_valid); end
  endtask
`else
  task automatic test_nonskid();
    out_ready = 0; in_valid = 1; in_data = 32'h54; in_ctrl = 8'h01;
    tick();
    in_data = 32'h55; in_ctrl = 8'h02; #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ns_valid got %b exp 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ns_ready_low got %b exp 0", in_ready); end
    out_ready = 1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ns_ready_comb got %b exp 1", in_ready); end
    tick();
    n_cmp++; if (out_data !== 32'h55) begin n_bad++; $display("FAIL ns_data got %h exp 55", out_data); end
    n_cmp++; if (occ !== 2'd1) begin n_bad++; $display("FAIL ns_occ got %0d exp 1", occ); end
    in_valid = 0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ns_drained got %b exp 0", out_valid); end
  endtask
`endif

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_data = 32'h77; in_ctrl = 8'h05;
    tick();
    n_cmp++; if (occ !== 2'd1) begin n_bad++; $display("FAIL fl_pre_occ got %0d exp 1", occ); end
    flush = 1; in_data = 32'hBEEF; in_ctrl = 8'hFF; out_ready = 1;
    tick();
    flush = 0; in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_ctrl !== 8'h0) begin n_bad++; $display("FAIL fl_ctrl got %h exp 0", out_ctrl); end
    n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL fl_occ got %0d exp 0", occ); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_later_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_data === 32'hBEEF) begin n_bad++; $display("FAIL fl_leak got %h exp not beef", out_data); end
  endtask

  task automatic test_counter();
    clr = 1; out_ready = 1; in_valid = 0;
    tick(); tick();
    clr = 0; out_ready = 0; in_valid = 1; in_data = 32'h1; in_ctrl = 8'h1;
    tick();
    in_valid = 0;
    repeat (5) tick();
    n_cmp++; if (stall !== 16'd5) begin n_bad++; $display("FAIL cnt5 got %0d exp 5", stall); end
    n_cmp++; if (stall3 !== 3'd5) begin n_bad++; $display("FAIL cnt5_w3 got %0d exp 5", stall3); end
    repeat (5) tick();
    n_cmp++; if (stall !== 16'd10) begin n_bad++; $display("FAIL cnt10 got %0d exp 10", stall); end
    n_cmp++; if (stall3 !== 3'd7) begin n_bad++; $display("FAIL cnt_sat_w3 got %0d exp 7", stall3); end
    clr = 1;
    tick();
    clr = 0;
    n_cmp++; if (stall !== 16'd0) begin n_bad++; $display("FAIL cnt_clr got %0d exp 0", stall); end
    n_cmp++; if (stall3 !== 3'd0) begin n_bad++; $display("FAIL cnt_clr_w3 got %0d exp 0", stall3); end
    tick(); tick();
    flush = 1;
    tick();
    flush = 0;
    n_cmp++; if (stall !== 16'd3) begin n_bad++; $display("FAIL cnt_flush got %0d exp 3", stall); end
    tick();
    n_cmp++; if (stall !== 16'd3) begin n_bad++; $display("FAIL cnt_hold got %0d exp 3", stall); end
  endtask

  task automatic test_random();
    bit ev;
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      clr       = ($urandom_range(0, 99) < 2);
      in_data   = $urandom;
      in_ctrl   = 8'($urandom);
      #1;
      n_cmp++; if (in_ready !== exp_in_ready()) begin n_bad++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", i, in_ready, exp_in_ready()); end
      n_cmp++; if (in_ready3 !== exp_in_ready()) begin n_bad++; $display("FAIL rnd_in_ready3[%0d] got %b exp %b", i, in_ready3, exp_in_ready()); end
      tick();
      ev = q.size() > 0;
      n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, ev); end
      n_cmp++; if (out_valid3 !== ev) begin n_bad++; $display("FAIL rnd_valid3[%0d] got %b exp %b", i, out_valid3, ev); end
      n_cmp++; if (occ !== 2'(q.size())) begin n_bad++; $display("FAIL rnd_occ[%0d] got %0d exp %0d", i, occ, q.size()); end
      n_cmp++; if (occ3 !== 2'(q.size())) begin n_bad++; $display("FAIL rnd_occ3[%0d] got %0d exp %0d", i, occ3, q.size()); end
      n_cmp++; if (stall !== 16'(cnt)) begin n_bad++; $display("FAIL rnd_stall[%0d] got %0d exp %0d", i, stall, cnt); end
      n_cmp++; if (stall3 !== 3'(cnt3)) begin n_bad++; $display("FAIL rnd_stall3[%0d] got %0d exp %0d", i, stall3, cnt3); end
      if (ev) begin
        n_cmp++; if (out_data !== q[0].d) begin n_bad++; $display("FAIL rnd_data[%0d] got %h exp %h", i, out_data, q[0].d); end
        n_cmp++; if (out_ctrl !== q[0].c) begin n_bad++; $display("FAIL rnd_ctrl[%0d] got %h exp %h", i, out_ctrl, q[0].c); end
        n_cmp++; if (out_data3 !== q[0].d) begin n_bad++; $display("FAIL rnd_data3[%0d] got %h exp %h", i, out_data3, q[0].d); end
        n_cmp++; if (out_ctrl3 !== q[0].c) begin n_bad++; $display("FAIL rnd_ctrl3[%0d] got %h exp %h", i, out_ctrl3, q[0].c); end
      end else begin
        n_cmp++; if (out_ctrl !== 8'h0) begin n_bad++; $display("FAIL rnd_bubble_ctrl[%0d] got %h exp 0", i, out_ctrl); end
        n_cmp++; if (out_ctrl3 !== 8'h0) begin n_bad++; $display("FAIL rnd_bubble_ctrl3[%0d] got %h exp 0", i, out_ctrl3); end
      end
    end
    idle_inputs();
    out_ready = 1;
    tick(); tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_drain got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
`ifdef PIPE_SKID_EN
    test_backpressure();
`else
    test_nonskid();
`endif
    idle_inputs();
    test_flush();
    idle_inputs();
    test_counter();
    idle_inputs();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Generic elastic pipeline stage replacing the fixed-field, always-enabled stage registers between processor stages (fetch/decode, decode/execute, execute/memory). It carries an arbitrary-width data payload and a separate control field through one registered stage with valid/ready handshaking. It adds:
- a flush that squashes in-flight entries;
- an optional 2-entry skid buffer for full throughput under back-pressure;
- a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32: payload width (register values, immediate, register indices packed by the instantiating stage).
- CTRL_W, 8: control-field width (regw/memw/regmem/ALU op/ALU ctrl bits); forced to zero on bubbles.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head-entry payload.
- out_ctrl  out  CTRL_W  head-entry control; 0 whenever out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 without skid).
- clr_cnt  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- In handshake: in_valid && in_ready. Out handshake: out_valid && out_ready. Entries leave in arrival order.
- States: EMPTY (0 entries), ONE (main slot valid), TWO (main + skid slot valid; skid build only).
- EMPTY: in handshake -> ONE; else stay.
- ONE, both handshakes -> ONE, main reloaded from input.
- ONE, in handshake only -> TWO, input captured in skid slot.
- ONE, out handshake only -> EMPTY.
- ONE, neither handshake -> stay.
- TWO: in_ready=0. Out handshake -> ONE, skid slot copied to main. Otherwise stay.
- out_valid = state != EMPTY. out_data/out_ctrl come from the main slot.
- flush: next state EMPTY and both slots' ctrl cleared, regardless of in_valid/out_ready. Any handshake in the flush cycle is discarded. Payload data regs may retain stale values.
- out_ctrl gated to 0 when out_valid=0, so a bubble is a guaranteed NOP downstream.
- stall_cnt: +1 each cycle with out_valid && !out_ready, saturating at all-ones.
  - clr_cnt has priority: the count is 0 on the next cycle.
  - flush does not clear stall_cnt.
- Reset (rst=0, any time, mid-transfer included): state EMPTY, slots zeroed, stall_cnt=0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0. in_ready is 1 with the skid build and 1 without it.

## Timing
- Latency 1 cycle: an entry accepted at edge N is on out_* after edge N, with out_valid=1 in cycle N+1.
- Skid build: in_ready is a pure register output (state != TWO). There is no combinational in_ready-to-out_ready path. Throughput is 1 entry/cycle.
- Non-skid build: in_ready = !out_valid || out_ready, a combinational path from out_ready.
- out_valid, out_data, occupancy are registered. out_ctrl is registered value AND out_valid.

## Configuration
- PIPE_SKID_EN defined: skid slot and TWO state present; registered in_ready; occupancy reaches 2.
- PIPE_SKID_EN undefined: single slot; combinational in_ready as above; TWO unreachable and occupancy[1] tied to 0.
- Handshake ordering and flush/counter behaviour are identical in both builds.

## Structure
- Shared package pipe_pkg holds:
  - the state enum typedef (EMPTY, ONE, TWO);
  - default-width constants (DATA_W_DEF=32, CTRL_W_DEF=8, CNT_W_DEF=16);
  - the saturating-counter max expression.
- Sub-module pipe_slot: one entry holding data + ctrl, with load enable and ctrl-clear. It uses the same asynchronous active-low reset and is instantiated once or twice.

## Test plan
- Reset mid-stream: 2 entries held, pull rst low -> same cycle out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0; after release, in_ready=1.
- Streaming: out_ready=1, in_data 0x10,0x11,0x12 on consecutive cycles -> out_data 0x10,0x11,0x12 one cycle later, out_valid held 1, no gaps.
- Back-pressure (skid): out_ready=0, send 0xA0 then 0xA1 -> occupancy=2, in_ready=0; raise out_ready -> out_data 0xA0 then 0xA1, in_ready=1 after first pop.
- Flush collision: occupancy=1, assert flush with in_valid=1, in_data=0xBEEF, in_ctrl=0xFF -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xBEEF never appears.
- Counter: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; with CNT_W=3, hold 10 cycles -> stall_cnt=7; clr_cnt -> 0 next cycle.
- Non-skid build: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1, in_data=0x55 -> in_ready=1, 0x55 on out_data next cycle.
